// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
// Fetch sequencer for a 32 x 8-bit instruction memory. It owns the PC,
// drives the memory read address and captures the combinational read data
// into the IF/ID pipeline register. It handles start, stall, branch redirect
// with flush, and end-of-program detection.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   i_start       begin fetching at START_PC (honoured in IDLE and DONE only)
//   i_stall       hold PC and IF/ID
//   i_br_taken    redirect to i_br_target and flush IF/ID
//   i_br_target   redirect address
//   o_imem_addr   instruction memory read address (the PC register)
//   i_imem_data   instruction memory read data, combinational from o_imem_addr
//   o_ifid_instr  IF/ID instruction register
//   o_ifid_pc     IF/ID PC register
//   o_ifid_valid  IF/ID holds a real instruction
//   o_busy        FSM in FETCH
//   o_done        FSM in DONE
//   o_fetch_cnt   saturating count of instructions issued since start
module instr_fetch_ctrl #(
    parameter logic [4:0]  START_PC = 5'd0,
    parameter logic [4:0]  LAST_PC  = 5'd27,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stall,
    input  logic             i_br_taken,
    input  logic [4:0]       i_br_target,
    output logic [4:0]       o_imem_addr,
    input  logic [7:0]       i_imem_data,
    output logic [7:0]       o_ifid_instr,
    output logic [4:0]       o_ifid_pc,
    output logic             o_ifid_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_fetch_cnt
);

    localparam int unsigned PC_W   = 5;
    localparam int unsigned INSN_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     w_pc_nxt;
    logic [INSN_W-1:0]   r_ifid_instr;
    logic [INSN_W-1:0]   w_ifid_instr_nxt;
    logic [PC_W-1:0]     r_ifid_pc;
    logic [PC_W-1:0]     w_ifid_pc_nxt;
    logic                r_ifid_valid;
    logic                w_ifid_valid_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;

    // Saturating increment of the issue counter
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : CNT_W'(r_cnt + 1'b1);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Next-state and datapath update; every register holds unless told otherwise
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_valid_nxt = r_ifid_valid;
        w_cnt_nxt        = r_cnt;

        unique case (r_state)
            ST_IDLE: begin
                // IF/ID is pinned at its reset contents while idle
                w_ifid_instr_nxt = '0;
                w_ifid_pc_nxt    = '0;
                w_ifid_valid_nxt = 1'b0;
                if (i_start) begin
                    w_pc_nxt    = START_PC;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (i_br_taken) begin
                    // Redirect wins over stall: the wrong-path slot becomes a bubble
                    w_pc_nxt         = i_br_target;
                    w_ifid_valid_nxt = 1'b0;
                    w_ifid_instr_nxt = '0;
                end else if (!i_stall) begin
                    w_ifid_instr_nxt = i_imem_data;
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_valid_nxt = 1'b1;
                    w_cnt_nxt        = w_cnt_inc;
                    if (r_pc == LAST_PC) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_pc_nxt = PC_W'(r_pc + 1'b1);
                    end
                end
            end
            ST_DONE: begin
                if (i_br_taken) begin
                    // Late-resolving branch after the final instruction was issued
                    w_pc_nxt         = i_br_target;
                    w_ifid_valid_nxt = 1'b0;
                    w_ifid_instr_nxt = '0;
                    w_state_nxt      = ST_FETCH;
                end else if (i_start) begin
                    w_pc_nxt         = START_PC;
                    w_cnt_nxt        = '0;
                    w_ifid_valid_nxt = 1'b0;
                    w_state_nxt      = ST_FETCH;
                end else if (!i_stall) begin
                    w_ifid_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_imem_addr  = r_pc;
    assign o_ifid_instr = r_ifid_instr;
    assign o_ifid_pc    = r_ifid_pc;
    assign o_ifid_valid = r_ifid_valid;
    assign o_fetch_cnt  = r_cnt;
    assign o_busy       = (r_state == ST_FETCH);
    assign o_done       = (r_state == ST_DONE);

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the 32 x 8-bit instruction memory. It owns the program counter, drives the memory read address, and captures the combinational read data into the IF/ID pipeline register. It handles start, stall, branch redirect with flush, and end-of-program detection. It sits between the instruction memory and the decode stage of the pipelined core.

Parameters:
START_PC, 5'd0, PC loaded when leaving IDLE on start
LAST_PC, 5'd27, address of the final program instruction; the fetch FSM enters DONE after issuing it
CNT_W, 8, width of the saturating fetch counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin fetching from START_PC; sampled in IDLE and DONE only
stall  in  1  decode or hazard stall; holds the PC and IF/ID
br_taken  in  1  branch or jump resolved taken; redirect and flush
br_target  in  5  redirect address
imem_addr  out  5  read address to instruction memory; equals pc_q (combinational)
imem_data  in  8  instruction memory read data; combinational from imem_addr
ifid_instr  out  8  IF/ID instruction register
ifid_pc  out  5  IF/ID PC register
ifid_valid  out  1  IF/ID holds a real instruction
busy  out  1  FSM is in FETCH
done  out  1  FSM is in DONE
fetch_cnt  out  CNT_W  number of instructions issued into IF/ID since start; saturates at all-ones

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. rst has priority over every other input.
- Reset values:
  - state = IDLE
  - pc_q = 0
  - ifid_instr = 8'h00, ifid_pc = 0, ifid_valid = 0
  - fetch_cnt = 0
  - busy = 0, done = 0
- Reset asserted mid-operation returns the block to these values on the next edge. Any in-flight IF/ID content is discarded.
- States: IDLE, FETCH, DONE. busy and done are decoded directly from the state register (Moore).
- IDLE:
  - IF/ID is held at reset values.
  - start=1 -> pc_q <= START_PC, fetch_cnt <= 0, go to FETCH.
  - stall and br_taken are ignored.
- FETCH, evaluated in priority order:
  1. br_taken=1 (beats stall) -> pc_q <= br_target; ifid_valid <= 0; ifid_instr <= 8'h00 (flush); stay in FETCH.
  2. stall=1 -> pc_q, ifid_*, and fetch_cnt all hold.
  3. Otherwise -> ifid_instr <= imem_data; ifid_pc <= pc_q; ifid_valid <= 1; fetch_cnt increments (saturating).
     - If pc_q == LAST_PC: go to DONE and hold pc_q.
     - Else: pc_q <= pc_q + 1, modulo 32 (31 wraps to 0).
- Fetch latency: an instruction at address A appears in ifid_instr one edge after imem_addr == A with stall=0. No bubbles occur in steady state: one instruction per cycle.
- Redirect penalty: exactly one bubble (ifid_valid=0). The instruction at br_target appears in IF/ID on the second edge after br_taken.
- DONE:
  - br_taken=1 -> pc_q <= br_target, flush IF/ID, go to FETCH. This covers a branch that resolves after the last instruction was issued.
  - Else start=1 -> pc_q <= START_PC, fetch_cnt <= 0, ifid_valid <= 0, go to FETCH.
  - Else stall=1 -> hold IF/ID.
  - Else -> ifid_valid <= 0 (drain); ifid_instr and ifid_pc hold.
- start in FETCH is ignored.
- A branch to LAST_PC is legal: that instruction is fetched once, then the FSM enters DONE.
- Combinational paths: imem_addr depends on pc_q only. There is no combinational path from any input to any output.

Test Plan:
- Reset then start with memory preloaded (addr1=8'h0B, addr2=8'h49, addr3=8'h12): after start, edges 2, 3, 4 show ifid_pc=0,1,2 with ifid_instr=8'h00, 8'h0B, 8'h49, ifid_valid=1, fetch_cnt=1,2,3.
- Stall for 3 cycles while ifid_pc=2: ifid_pc, ifid_instr and imem_addr=3 hold for 3 edges; the first edge after release shows ifid_pc=3, ifid_instr=8'h12.
- br_taken=1, br_target=5'd20, asserted together with stall=1: the next edge gives ifid_valid=0 and imem_addr=20; the edge after gives ifid_pc=20, ifid_instr=8'h01.
- Run from 0 to LAST_PC=27 with no stall or branch: done=1 and busy=0 on the edge issuing ifid_pc=27; ifid_valid drops the following edge; fetch_cnt=28; a further start restarts at pc 0 with fetch_cnt=0.
- LAST_PC=31 with a branch to 30: fetches 30 and 31, then DONE; imem_addr never wraps to 0.
- rst=1 asserted in FETCH at pc=12: on the next edge all outputs are at reset values and the FSM is in IDLE; stall and br_taken applied in IDLE have no effect.
